// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the busy-counter width.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MAX_CYCLES      = 15;
  localparam int CNT_W           = $clog2(MAX_CYCLES + 1);

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit result generator for the MDU: {HI, LO} for
// mult/multu/div/divu plus a divide-by-zero flag.
module e_mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_dz
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic               w_bz;
  logic               w_ovf;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic        [31:0] w_ub;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic        [31:0] w_uq;
  logic        [31:0] w_ur;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Divisor is forced to 1 for the zero and overflow cases so the dividers
  // never see an undefined operation; those results are overridden below.
  assign w_bz  = (i_b == 32'd0);
  assign w_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_sa  = $signed(i_a);
  assign w_sb  = (w_bz || w_ovf) ? 32'sd1 : $signed(i_b);
  assign w_ub  = w_bz ? 32'd1 : i_b;
  assign w_sq  = w_sa / w_sb;
  assign w_sr  = w_sa % w_sb;
  assign w_uq  = i_a / w_ub;
  assign w_ur  = i_a % w_ub;

  always_comb begin
    o_res = 64'd0;
    o_dz  = 1'b0;
    case (mdu_op_e'(i_op))
      MDU_MULT:  o_res = w_sprod;
      MDU_MULTU: o_res = w_uprod;
      MDU_DIV: begin
        o_res = w_ovf ? {32'd0, 32'h8000_0000} : {w_sr, w_sq};
        o_dz  = w_bz;
      end
      MDU_DIVU: begin
        o_res = {w_ur, w_uq};
        o_dz  = w_bz;
      end
      default: o_res = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: busy counter, pending result, HI/LO and read mux.
// Optional start-cancel input enabled by `define MDU_CANCEL_EN.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start_in,
  input  logic [2:0]  MDUOp_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel_in,
`endif
  input  logic        HiLoSel_in,
  output logic        Busy_out,
  output logic [31:0] HiLo_out
);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_dz;

  logic [63:0]      w_res;
  logic             w_dz;
  logic             w_busy;
  logic             w_start;
  logic             w_is_mul;
  logic             w_is_div;

  e_mdu_calc u_calc (
    .i_op  (MDUOp_in),
    .i_a   (A_in),
    .i_b   (B_in),
    .o_res (w_res),
    .o_dz  (w_dz)
  );

  assign w_busy = (r_cnt != '0);
`ifdef MDU_CANCEL_EN
  assign w_start = Start_in && !w_busy && !Cancel_in;
`else
  assign w_start = Start_in && !w_busy;
`endif
  assign w_is_mul = (MDUOp_in == MDU_MULT) || (MDUOp_in == MDU_MULTU);
  assign w_is_div = (MDUOp_in == MDU_DIV)  || (MDUOp_in == MDU_DIVU);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      // Commit on the last busy edge; a divide by zero leaves HI/LO alone.
      if (r_cnt == CNT_W'(1) && !r_pend_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_start) begin
      if (w_is_mul || w_is_div) begin
        r_pend_hi <= w_res[63:32];
        r_pend_lo <= w_res[31:0];
        r_pend_dz <= w_dz;
        r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (MDUOp_in == MDU_MTHI) begin
        r_hi <= A_in;
      end else if (MDUOp_in == MDU_MTLO) begin
        r_lo <= A_in;
      end
    end
  end

  assign Busy_out = w_busy;
  assign HiLo_out = HiLoSel_in ? r_hi : r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed test-plan cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start_in;
  logic [2:0]  MDUOp_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        HiLoSel_in;
  logic        Busy_out;
  logic [31:0] HiLo_out;
`ifdef MDU_CANCEL_EN
  logic        Cancel_in;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 Clk = ~Clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start_in   (Start_in),
    .MDUOp_in   (MDUOp_in),
    .A_in       (A_in),
    .B_in       (B_in),
`ifdef MDU_CANCEL_EN
    .Cancel_in  (Cancel_in),
`endif
    .HiLoSel_in (HiLoSel_in),
    .Busy_out   (Busy_out),
    .HiLo_out   (HiLo_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_hilo(input string tag);
    HiLoSel_in = 1'b1;
    #1 chk({tag, ".hi"}, HiLo_out, m_hi);
    HiLoSel_in = 1'b0;
    #1 chk({tag, ".lo"}, HiLo_out, m_lo);
  endtask

  // Reference: what HI/LO should become and how many busy cycles it takes.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    n = 0; nh = m_hi; nl = m_lo;
    case (op)
      3'd1: begin n = MC; p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
      3'd2: begin n = MC; p = ua * ub; nh = p[63:32]; nl = p[31:0]; end
      3'd3: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
      end
      3'd4: begin
        n = DC;
        if (b != 0) begin q = ua / ub; r = ua % ub; nh = r[31:0]; nl = q[31:0]; end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] nh, nl;
    model(op, a, b, n, nh, nl);
    Start_in = 1'b1; MDUOp_in = op; A_in = a; B_in = b;
    step();
    Start_in = 1'b0; A_in = $urandom; B_in = $urandom;
    for (int i = 1; i <= n; i++) begin
      chk({tag, ".busy"}, {31'd0, Busy_out}, 32'd1);
      if (i == 1) chk_hilo({tag, ".old"});
      step();
    end
    chk({tag, ".idle"}, {31'd0, Busy_out}, 32'd0);
    m_hi = nh; m_lo = nl;
    chk_hilo(tag);
  endtask

  initial begin
    int n;
    logic [31:0] nh, nl;
    Rst = 1'b1; Start_in = 1'b0; MDUOp_in = 3'd0; A_in = '0; B_in = '0; HiLoSel_in = 1'b0;
`ifdef MDU_CANCEL_EN
    Cancel_in = 1'b0;
`endif
    m_hi = '0; m_lo = '0;
    step(); step();
    chk("rst.busy", {31'd0, Busy_out}, 32'd0);
    chk_hilo("rst");
    Rst = 1'b0;
    step();

    run("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult.hi_const", m_hi, 32'hFFFF_FFFF);
    run("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run("divu0", 3'd4, 32'd7, 32'd0);
    run("div0", 3'd3, 32'd5, 32'd0);
    run("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run("mthi", 3'd5, 32'h1234_5678, 32'd0);
    run("mtlo", 3'd6, 32'hCAFE_F00D, 32'd0);
    run("none", 3'd0, 32'h1111_1111, 32'd2);
    run("rsvd", 3'd7, 32'h2222_2222, 32'd3);

    // MTHI pulsed in the middle of a divide must be ignored.
    model(3'd4, 32'd100, 32'd7, n, nh, nl);
    Start_in = 1'b1; MDUOp_in = 3'd4; A_in = 32'd100; B_in = 32'd7;
    step();
    for (int i = 1; i <= DC; i++) begin
      chk("divmthi.busy", {31'd0, Busy_out}, 32'd1);
      Start_in = (i == 2); MDUOp_in = 3'd5; A_in = 32'hDEAD_BEEF;
      step();
    end
    Start_in = 1'b0;
    chk("divmthi.idle", {31'd0, Busy_out}, 32'd0);
    m_hi = nh; m_lo = nl;
    chk_hilo("divmthi");

    // Reset in the third busy cycle of a multiply.
    Start_in = 1'b1; MDUOp_in = 3'd1; A_in = 32'd1000; B_in = 32'd1000;
    step();
    Start_in = 1'b0;
    step(); step();
    chk("rstbusy.pre", {31'd0, Busy_out}, 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("rstbusy.busy", {31'd0, Busy_out}, 32'd0);
    chk_hilo("rstbusy");
    for (int i = 0; i < MC + 2; i++) step();
    chk("rstbusy.late_busy", {31'd0, Busy_out}, 32'd0);
    chk_hilo("rstbusy.late");

`ifdef MDU_CANCEL_EN
    run("premult", 3'd1, 32'd12345, 32'd678);
    Start_in = 1'b1; Cancel_in = 1'b1; MDUOp_in = 3'd1; A_in = 32'd3; B_in = 32'd4;
    step();
    Start_in = 1'b0; Cancel_in = 1'b0;
    for (int i = 0; i < MC + 1; i++) begin
      chk("cancel.busy", {31'd0, Busy_out}, 32'd0);
      step();
    end
    chk_hilo("cancel");
    Start_in = 1'b1; Cancel_in = 1'b1; MDUOp_in = 3'd5; A_in = 32'h5555_AAAA;
    step();
    Start_in = 1'b0; Cancel_in = 1'b0;
    chk_hilo("cancel_mthi");
`endif

    for (int k = 0; k < 16; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      run("rand", op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
